// File: rtl/mux8_arbiter_pkg.sv
// Shared types and constants for the eight-way round-robin word arbiter.
// The state encoding is fixed so that checkers can decode the debug state output directly.
package mux8_arbiter_pkg;

   localparam int NUM_REQ = 8;
   localparam int WORD_W  = 16;

   // Encoding 2'd3 is unused and falls back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   function automatic logic [NUM_REQ-1:0] onehot8(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/Mux8Way16.sv
// Eight-way 16-bit word multiplexer shared by the datapath result bus.
module Mux8Way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out
);

   always_comb begin
      case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         default: out = h;
      endcase
   end

endmodule

// File: rtl/mux8_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 7 to 0.
module rr_pick8
   import mux8_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic [2:0]         idx,
   output logic               any
);

   logic [2:0] w_cand;

   // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
   always_comb begin
      idx    = 3'd0;
      any    = 1'b0;
      w_cand = 3'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = ptr + 3'(k);
         if (req[w_cand]) begin
            idx = w_cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter that owns the shared 8-way word multiplexer and hands the
// selected word to one consumer over valid/ready, acking the owning requester.
module mux8_arbiter
   import mux8_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQ-1:0]  req,
   input  logic [WORD_W-1:0]   a,
   input  logic [WORD_W-1:0]   b,
   input  logic [WORD_W-1:0]   c,
   input  logic [WORD_W-1:0]   d,
   input  logic [WORD_W-1:0]   e,
   input  logic [WORD_W-1:0]   f,
   input  logic [WORD_W-1:0]   g,
   input  logic [WORD_W-1:0]   h,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out,
   output logic                out_valid,
   output logic [NUM_REQ-1:0]  grant,
   output logic [2:0]          sel,
   output logic [NUM_REQ-1:0]  ack,
   output logic [1:0]          dbg_state
);

   // Handshake: a word transfers in exactly the cycle where out_valid and
   // out_ready are both 1; out and grant stay frozen while out_valid waits.

   state_t              r_state;
   logic [2:0]          r_ptr;
   logic [2:0]          r_sel;
   logic [NUM_REQ-1:0]  r_grant;
   logic [WORD_W-1:0]   r_out;
   logic                r_valid;

   logic [2:0]          w_idx;
   logic                w_any;
   logic [WORD_W-1:0]   w_mux;
   logic                w_accept;

   rr_pick8 u_pick (
      .req (req),
      .ptr (r_ptr),
      .idx (w_idx),
      .any (w_any)
   );

   Mux8Way16 u_mux (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .e   (e),
      .f   (f),
      .g   (g),
      .h   (h),
      .sel (r_sel),
      .out (w_mux)
   );

   // Gated by reset so a word caught by reset is dropped without an ack.
   assign w_accept = (r_state == ST_WAIT) && r_valid && out_ready && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= 3'd0;
         r_sel   <= 3'd0;
         r_grant <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_sel   <= w_idx;
                  r_grant <= onehot8(w_idx);
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_out   <= w_mux;
               r_valid <= 1'b1;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_accept) begin
                  r_valid <= 1'b0;
                  r_grant <= '0;
                  r_ptr   <= r_sel + 3'd1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_grant <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid;
   assign grant     = r_grant;
   assign sel       = r_sel;
   assign ack       = w_accept ? onehot8(r_sel) : '0;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Self-checking bench for mux8_arbiter: directed scenarios followed by random
// transactions, each checked against a transaction-level round-robin model.
module tb_mux8_arbiter;

   logic        clk;
   logic        reset;
   logic [7:0]  req;
   logic [15:0] d_arr [8];
   logic        out_ready;
   logic [15:0] out;
   logic        out_valid;
   logic [7:0]  grant;
   logic [2:0]  sel;
   logic [7:0]  ack;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_fail;
   int m_ptr;

   mux8_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a         (d_arr[0]),
      .b         (d_arr[1]),
      .c         (d_arr[2]),
      .d         (d_arr[3]),
      .e         (d_arr[4]),
      .f         (d_arr[5]),
      .g         (d_arr[6]),
      .h         (d_arr[7]),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .grant     (grant),
      .sel       (sel),
      .ack       (ack),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: scan requesters starting at the pointer, modulo 8.
   function automatic int model_pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [7:0] bit_of(input int i);
      logic [7:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic randomize_data();
      for (int i = 0; i < 8; i++) d_arr[i] = 16'($urandom_range(0, 16'hFFFF));
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req       = 8'hFF;
      out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("rst_out", 32'(out), 32'h0);
         check("rst_valid", 32'(out_valid), 32'h0);
         check("rst_grant", 32'(grant), 32'h0);
         check("rst_sel", 32'(sel), 32'h0);
         check("rst_ack", 32'(ack), 32'h0);
         check("rst_state", 32'(dbg_state), 32'h0);
      end
      reset     = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      m_ptr     = 0;
   endtask

   // Called mid-cycle with the DUT idle; returns mid-cycle with the DUT idle again.
   task automatic run_txn(input logic [7:0] r, input int delay, input bit drop);
      int          w;
      logic [15:0] exp_word;
      logic [7:0]  exp_oh;
      w        = model_pick(r, m_ptr);
      exp_word = d_arr[w];
      exp_oh   = bit_of(w);
      req       = r;
      out_ready = (delay == 0);
      @(posedge clk); #1;
      if (drop) req = r & ~exp_oh;
      @(negedge clk);
      check("g_state", 32'(dbg_state), 32'd1);
      check("g_grant", 32'(grant), 32'(exp_oh));
      check("g_sel", 32'(sel), 32'(w));
      check("g_valid", 32'(out_valid), 32'h0);
      check("g_ack", 32'(ack), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("w_valid", 32'(out_valid), 32'h1);
      check("w_out", 32'(out), 32'(exp_word));
      check("w_grant", 32'(grant), 32'(exp_oh));
      check("w_ack", 32'(ack), (delay == 0) ? 32'(exp_oh) : 32'h0);
      for (int i = 0; i < delay; i++) begin
         @(posedge clk); #1;
         if (i == delay - 1) out_ready = 1'b1;
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'h1);
         check("bp_out", 32'(out), 32'(exp_word));
         check("bp_grant", 32'(grant), 32'(exp_oh));
         check("bp_sel", 32'(sel), 32'(w));
         check("bp_ack", 32'(ack), (i == delay - 1) ? 32'(exp_oh) : 32'h0);
      end
      @(posedge clk); #1;
      req       = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      check("i_valid", 32'(out_valid), 32'h0);
      check("i_grant", 32'(grant), 32'h0);
      check("i_ack", 32'(ack), 32'h0);
      check("i_state", 32'(dbg_state), 32'h0);
      m_ptr = (w + 1) % 8;
   endtask

   task automatic reset_in_wait(input logic [7:0] r);
      req       = r;
      out_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("rw_valid_before", 32'(out_valid), 32'h1);
      check("rw_ack_in_reset", 32'(ack), 32'h0);
      @(posedge clk); #1;
      reset     = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      check("rw_valid_after", 32'(out_valid), 32'h0);
      check("rw_grant_after", 32'(grant), 32'h0);
      check("rw_ack_after", 32'(ack), 32'h0);
      check("rw_state_after", 32'(dbg_state), 32'h0);
      m_ptr = 0;
   endtask

   initial begin
      logic [7:0] r;
      n_checks  = 0;
      n_fail    = 0;
      m_ptr     = 0;
      reset     = 1'b1;
      req       = 8'h00;
      out_ready = 1'b0;
      randomize_data();

      // Reset with all requests pending, then requester 0 wins first.
      do_reset();
      run_txn(8'hFF, 0, 1'b0);

      // Single request delivered with minimum latency.
      do_reset();
      randomize_data();
      d_arr[3] = 16'hBEEF;
      run_txn(8'h08, 0, 1'b0);

      // Full rotation from a fresh pointer, then wrap behaviour with 8'h81.
      do_reset();
      randomize_data();
      for (int i = 0; i < 8; i++) run_txn(8'hFF, 0, 1'b0);
      run_txn(8'h81, 0, 1'b0);
      run_txn(8'h81, 0, 1'b0);

      // Backpressure on requester 5.
      d_arr[5] = 16'h1234;
      run_txn(8'h20, 5, 1'b0);

      // Requester 2 drops its request during the capture cycle.
      d_arr[2] = 16'h00A5;
      run_txn(8'h04, 0, 1'b1);

      // Move the pointer away from 0, reset while waiting, confirm pointer restart.
      run_txn(8'h10, 1, 1'b0);
      reset_in_wait(8'h40);
      run_txn(8'hFF, 0, 1'b0);

      // Random traffic.
      for (int t = 0; t < 60; t++) begin
         randomize_data();
         r = 8'($urandom_range(1, 255));
         run_txn(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL timeout: simulation exceeded time budget");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin arbiter and sequencer that shares one 8-way 16-bit word multiplexer among eight requesters and delivers the selected word to a single downstream consumer over a valid/ready handshake. Each requester holds a request line and a stable 16-bit word. The block chooses one requester, drives the multiplexer select, registers the multiplexer output, and acknowledges the requester once the consumer accepts the word. It sits between the register and ALU sources and the shared result bus of the datapath.

## Interface
- No parameters: word width fixed at 16, requester count fixed at 8.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 8: request vector; bit i asserted by requester i.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h` in 16 each: requester 0..7 data words, fed to the internal multiplexer.
- `out_ready` in 1: consumer can accept `out`.
- `out` out 16: registered selected word.
- `out_valid` out 1: `out` holds a word not yet accepted.
- `grant` out 8: one-hot, identifies the requester currently owning the multiplexer.
- `sel` out 3: binary index of the granted requester, also drives the internal multiplexer.
- `ack` out 8: one-cycle one-hot pulse to the requester whose word was accepted.

## Operation
- States:
  - IDLE: `grant`=0.
  - GRANT: capture cycle.
  - WAIT: `out_valid`=1.
- IDLE:
  - If `req`≠0, pick the first set bit searching upward from `ptr` with wrap 7→0.
  - Register `sel` and `grant`, then go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT:
  - Multiplexer output for `sel` is latched into `out`.
  - Go to WAIT.
- WAIT:
  - `out` and `grant` held stable while `out_ready`=0.
  - On `out_valid`&&`out_ready`: `ack[sel]`=1 for that cycle, `ptr`←`sel`+1 mod 8 (7 wraps to 0), `grant`←0, go to IDLE.
- `ptr` is a 3-bit internal pointer; reset value 0, so requester 0 has first priority.
- Requesters hold `req` and data stable until `ack`. If `req[i]` drops during GRANT or WAIT, the captured word is still delivered and `ack[i]` still pulses.
- New requests arriving during GRANT or WAIT are ignored until the next IDLE.

## Timing
- Reset values: `out`=0, `out_valid`=0, `grant`=0, `sel`=0, `ack`=0, state IDLE, `ptr`=0.
- Cycle n, IDLE with `req`≠0 → cycle n+1 GRANT with `grant`/`sel` valid → cycle n+2 WAIT with `out_valid`=1.
- If `out_ready`=1 at n+2, `ack` pulses at n+2 and the block is back in IDLE at n+3.
- Minimum spacing is 3 cycles per word with `out_ready` tied high.
- `out_ready` may be high before `out_valid` rises; acceptance occurs only in a cycle where both are 1.
- `reset` asserted in any state: next edge forces all reset values. Any pending word is discarded, no `ack` is issued, and `ptr` returns to 0.
- `ack` is never asserted in the same cycle as `reset`.

## Structure
- Shared package `mux8_arbiter_pkg`:
  - State encoding IDLE=2'd0, GRANT=2'd1, WAIT=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Constants `NUM_REQ`=8 and `WORD_W`=16.
- Instantiates the codebase's existing `Mux8Way16` for the datapath.
- Sub-module `rr_pick8`: combinational round-robin picker.
  - Inputs `req[7:0]` and `ptr[2:0]`.
  - Outputs `idx[2:0]` and `any`.
- Top level holds the FSM, `ptr`, and the output register.

## Test plan
- **Reset:** hold `reset` 2 cycles with `req`=8'hFF → all outputs 0. First grant after release is requester 0 (`sel`=0, `grant`=8'h01).
- **Single request:** `req`=8'h08, `d`=16'hBEEF, `out_ready`=1 → `out`=16'hBEEF with `out_valid` at cycle 2, `ack`=8'h08 at cycle 2, IDLE at cycle 3.
- **Round-robin:**
  - `req`=8'hFF held with all data distinct → grant order 0,1,…,7,0.
  - Then `req`=8'h81 after requester 7 → next grant 0, then 7.
- **Backpressure:** `out_ready`=0 for 5 cycles in WAIT with `f`=16'h1234 granted → `out`, `grant`=8'h20 and `sel`=5 stable, no `ack`. Raising `out_ready` gives one `ack`=8'h20.
- **Request drop:** `req[2]` deasserted in GRANT with `c`=16'h00A5 → word 16'h00A5 still delivered and `ack`=8'h04 pulses.
- **Reset mid-operation:** `reset` in WAIT with `out_valid`=1 → next cycle `out_valid`=0, no `ack`, `ptr`=0.
